// File: rtl/execid_sequencer_if.sv
// Command/response bus of the execution-ID sequencer.
//   cmd_valid/cmd_ready/cmd_op          : command handshake (op 0=ZERO 1=INC 2=DESCEND 3=ASCEND)
//   res_valid/res_ready/res_id/res_err  : response handshake carrying the resulting ID
// master: command issuer / response consumer; slave: the sequencer.
interface execid_sequencer_if #(
    parameter int WIDTH = 32
) ();
    logic             cmd_valid;
    logic             cmd_ready;
    logic [1:0]       cmd_op;
    logic             res_valid;
    logic             res_ready;
    logic [WIDTH-1:0] res_id;
    logic             res_err;

    modport master (
        output cmd_valid, cmd_op, res_ready,
        input  cmd_ready, res_valid, res_id, res_err
    );

    modport slave (
        input  cmd_valid, cmd_op, res_ready,
        output cmd_ready, res_valid, res_id, res_err
    );
endinterface

// File: rtl/execid_sequencer.sv
// Execution-ID sequencer: owns the running ID register and applies
// ZERO / INC / DESCEND / ASCEND commands, scanning one 8-bit slot per cycle.
// Slot i is id[8i+7:8i]; the highest slot is the outermost nesting level,
// the lowest nonzero slot is the innermost active level.
// Ports:
//   clk, rst  : clock, synchronous active-high reset
//   bus       : command/response handshake (slave side)
//   id_cur    : current ID register
//   depth     : active nesting depth (NSLOTS - lowest nonzero index, 0 if id==0)
//   err       : sticky error flag
//   err_code  : code of first error (1=NO_ACTIVE 2=OVERFLOW 3=FULL)
module execid_sequencer #(
    parameter int WIDTH    = 32,
    parameter int SLOTBITS = 8
) (
    input  logic                                   clk,
    input  logic                                   rst,
    execid_sequencer_if.slave                      bus,
    output logic [WIDTH-1:0]                       id_cur,
    output logic [$clog2(WIDTH/SLOTBITS+1)-1:0]    depth,
    output logic                                   err,
    output logic [1:0]                             err_code
);
    localparam int NSLOTS = WIDTH / SLOTBITS;
    localparam int IW     = $clog2(NSLOTS);
    localparam int DW     = $clog2(NSLOTS + 1);

    localparam logic [IW-1:0]       IDX_LAST = IW'(NSLOTS - 1);
    localparam logic [IW-1:0]       IDX_ONE  = IW'(1);
    localparam logic [SLOTBITS-1:0] SLOT_ONE = SLOTBITS'(1);
    localparam logic [SLOTBITS-1:0] SLOT_MAX = '1;

    if (SLOTBITS != 8 || WIDTH < 16 || (WIDTH % SLOTBITS) != 0) begin : g_bad_params
        $error("execid_sequencer: WIDTH must be a multiple of 8 and >= 16, SLOTBITS must be 8");
    end

    typedef enum logic [1:0] {IDLE, SCAN, UPDATE, RESP} state_t;
    typedef enum logic [1:0] {OP_ZERO, OP_INC, OP_DESCEND, OP_ASCEND} op_t;
    typedef enum logic [1:0] {E_NONE, E_NO_ACTIVE, E_OVERFLOW, E_FULL} err_t;

    state_t              state_q, state_d;
    op_t                 op_q;
    logic [IW-1:0]       k_q, lo_q, hi_q, up_idx;
    logic                lo_v_q, hi_v_q, last_slot;
    logic [WIDTH-1:0]    id_q, res_id_q, id_new;
    logic                res_err_q, err_q, found;
    logic [DW-1:0]       depth_q, depth_new;
    err_t                err_code_q, code_new;
    logic [SLOTBITS-1:0] scan_slot, lo_slot, up_slot;

    assign scan_slot = id_q[k_q*SLOTBITS +: SLOTBITS];
    assign last_slot = (k_q == IDX_LAST);
    // Clamp so the slot read stays in range; the lo==last case is rejected anyway.
    assign up_idx    = (lo_q == IDX_LAST) ? lo_q : lo_q + IDX_ONE;
    assign lo_slot   = id_q[lo_q*SLOTBITS +: SLOTBITS];
    assign up_slot   = id_q[up_idx*SLOTBITS +: SLOTBITS];

    assign bus.cmd_ready = (state_q == IDLE);
    assign bus.res_valid = (state_q == RESP);
    assign bus.res_id    = res_id_q;
    assign bus.res_err   = res_err_q;
    assign id_cur        = id_q;
    assign depth         = depth_q;
    assign err           = err_q;
    assign err_code      = err_code_q;

    always_ff @(posedge clk) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (bus.cmd_valid) state_d = SCAN;
            SCAN:    if (last_slot)     state_d = UPDATE;
            UPDATE:  state_d = RESP;
            RESP:    if (bus.res_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Candidate new ID and error code from the scan results.
    always_comb begin
        id_new   = id_q;
        code_new = E_NONE;
        case (op_q)
            OP_ZERO: id_new = '0;
            OP_INC: begin
                if (!lo_v_q)                code_new = E_NO_ACTIVE;
                else if (lo_slot == SLOT_MAX) code_new = E_OVERFLOW;
                else id_new[lo_q*SLOTBITS +: SLOTBITS] = lo_slot + SLOT_ONE;
            end
            OP_DESCEND: begin
                if (!hi_v_q) code_new = E_FULL;
                else id_new[hi_q*SLOTBITS +: SLOTBITS] = SLOT_ONE;
            end
            OP_ASCEND: begin
                if (!lo_v_q) code_new = E_NO_ACTIVE;
                else if (lo_q == IDX_LAST || up_slot == SLOT_MAX) code_new = E_OVERFLOW;
                else begin
                    id_new[lo_q*SLOTBITS +: SLOTBITS]   = '0;
                    id_new[up_idx*SLOTBITS +: SLOTBITS] = up_slot + SLOT_ONE;
                end
            end
            default: ;
        endcase
        if (code_new != E_NONE) id_new = id_q;
    end

    always_comb begin
        depth_new = '0;
        found     = 1'b0;
        for (int unsigned i = 0; i < NSLOTS; i++) begin
            if (!found && id_new[i*SLOTBITS +: SLOTBITS] != '0) begin
                depth_new = DW'(NSLOTS - i);
                found     = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            op_q       <= OP_ZERO;
            k_q        <= '0;
            lo_q       <= '0;
            hi_q       <= '0;
            lo_v_q     <= 1'b0;
            hi_v_q     <= 1'b0;
            id_q       <= '0;
            res_id_q   <= '0;
            res_err_q  <= 1'b0;
            depth_q    <= '0;
            err_q      <= 1'b0;
            err_code_q <= E_NONE;
        end else begin
            case (state_q)
                IDLE: if (bus.cmd_valid) begin
                    op_q   <= op_t'(bus.cmd_op);
                    k_q    <= '0;
                    lo_v_q <= 1'b0;
                    hi_v_q <= 1'b0;
                end
                SCAN: begin
                    if (scan_slot != '0 && !lo_v_q) begin
                        lo_v_q <= 1'b1;
                        lo_q   <= k_q;
                    end
                    // Ascending scan: the last zero seen is the highest zero slot.
                    if (scan_slot == '0) begin
                        hi_v_q <= 1'b1;
                        hi_q   <= k_q;
                    end
                    k_q <= k_q + IDX_ONE;
                end
                UPDATE: begin
                    id_q      <= id_new;
                    res_id_q  <= id_new;
                    res_err_q <= (code_new != E_NONE);
                    depth_q   <= depth_new;
                    if (code_new != E_NONE && !err_q) begin
                        err_q      <= 1'b1;
                        err_code_q <= code_new;
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_execid_sequencer.sv
module tb_execid_sequencer;
    localparam int WIDTH  = 32;
    localparam int NSLOTS = 4;
    localparam int DW     = 3;
    localparam logic [1:0] ZERO = 2'd0, INC = 2'd1, DESC = 2'd2, ASC = 2'd3;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    execid_sequencer_if #(.WIDTH(WIDTH)) bus ();
    logic [WIDTH-1:0] id_cur;
    logic [DW-1:0]    depth;
    logic             err;
    logic [1:0]       err_code;

    execid_sequencer #(.WIDTH(WIDTH)) dut (
        .clk(clk), .rst(rst), .bus(bus),
        .id_cur(id_cur), .depth(depth), .err(err), .err_code(err_code)
    );

    int checks   = 0;
    int failures = 0;

    // Reference model state
    logic [31:0] m_id;
    logic        m_err;
    logic [1:0]  m_code;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    function automatic int mdepth(input logic [31:0] v);
        for (int k = 0; k < NSLOTS; k++)
            if (((v >> (8*k)) & 32'hFF) != 0) return NSLOTS - k;
        return 0;
    endfunction

    // Apply one command to the model; returns whether it is rejected.
    task automatic model_apply(input logic [1:0] op, output logic rejected);
        int sl[NSLOTS];
        int lo = -1, hi = -1, code = 0;
        for (int k = 0; k < NSLOTS; k++) begin
            sl[k] = int'((m_id >> (8*k)) & 32'hFF);
            if (sl[k] != 0 && lo < 0) lo = k;
            if (sl[k] == 0) hi = k;
        end
        case (op)
            ZERO: for (int k = 0; k < NSLOTS; k++) sl[k] = 0;
            INC: begin
                if (lo < 0) code = 1;
                else if (sl[lo] + 1 > 255) code = 2;
                else sl[lo] = sl[lo] + 1;
            end
            DESC: begin
                if (hi < 0) code = 3;
                else sl[hi] = 1;
            end
            default: begin
                if (lo < 0) code = 1;
                else if (lo == NSLOTS-1 || sl[lo+1] + 1 > 255) code = 2;
                else begin
                    sl[lo]   = 0;
                    sl[lo+1] = sl[lo+1] + 1;
                end
            end
        endcase
        rejected = (code != 0);
        if (rejected) begin
            if (!m_err) begin
                m_err  = 1'b1;
                m_code = 2'(code);
            end
        end else begin
            m_id = 0;
            for (int k = 0; k < NSLOTS; k++) m_id = m_id | (32'(sl[k]) << (8*k));
        end
    endtask

    task automatic chk_reset_outputs();
        chk("rst_res_valid", bus.res_valid, 0);
        chk("rst_res_id",    bus.res_id, 0);
        chk("rst_res_err",   bus.res_err, 0);
        chk("rst_id_cur",    id_cur, 0);
        chk("rst_depth",     depth, 0);
        chk("rst_err",       err, 0);
        chk("rst_err_code",  err_code, 0);
        chk("rst_cmd_ready", bus.cmd_ready, 1);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        bus.cmd_valid = 1'b0;
        bus.res_ready = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        m_id = 0; m_err = 1'b0; m_code = 2'd0;
        chk_reset_outputs();
    endtask

    // Issue one command, hold off res_ready for bp cycles, check everything.
    task automatic send_cmd(input logic [1:0] op, input int bp);
        logic [31:0] prev;
        logic        rej;
        int          cyc;
        @(negedge clk);
        chk("idle_cmd_ready", bus.cmd_ready, 1);
        bus.cmd_valid = 1'b1;
        bus.cmd_op    = op;
        bus.res_ready = (bp == 0);
        prev = m_id;
        @(posedge clk);
        @(negedge clk);
        bus.cmd_valid = 1'b0;
        bus.cmd_op    = 2'($urandom_range(0, 3));
        chk("scan_cmd_ready", bus.cmd_ready, 0);
        chk("scan_id_cur", id_cur, prev);
        cyc = 0;
        while (!bus.res_valid && cyc < 20) begin
            @(negedge clk);
            cyc++;
        end
        chk("res_latency", cyc, NSLOTS + 1);
        model_apply(op, rej);
        chk("res_valid", bus.res_valid, 1);
        chk("res_id",    bus.res_id, m_id);
        chk("res_err",   bus.res_err, rej);
        chk("id_cur",    id_cur, m_id);
        chk("depth",     depth, mdepth(m_id));
        chk("err",       err, m_err);
        chk("err_code",  err_code, m_code);
        for (int i = 0; i < bp; i++) begin
            @(negedge clk);
            chk("bp_res_valid", bus.res_valid, 1);
            chk("bp_res_id",    bus.res_id, m_id);
            chk("bp_res_err",   bus.res_err, rej);
            chk("bp_id_cur",    id_cur, m_id);
            chk("bp_cmd_ready", bus.cmd_ready, 0);
        end
        bus.res_ready = 1'b1;
        @(negedge clk);
        chk("done_res_valid", bus.res_valid, 0);
        chk("done_cmd_ready", bus.cmd_ready, 1);
        bus.res_ready = 1'b0;
    endtask

    initial begin
        logic seen;
        logic [1:0] op;
        rst = 1'b1;
        bus.cmd_valid = 1'b0;
        bus.cmd_op    = 2'd0;
        bus.res_ready = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        m_id = 0; m_err = 1'b0; m_code = 2'd0;
        chk_reset_outputs();

        // Nesting then counting
        send_cmd(DESC, 0);
        chk("plan_d1", id_cur, 32'h0100_0000);
        send_cmd(DESC, 0);
        chk("plan_d2", id_cur, 32'h0101_0000);
        repeat (3) send_cmd(INC, 0);
        chk("plan_inc3", id_cur, 32'h0104_0000);
        chk("plan_depth2", depth, 2);
        chk("plan_no_err", err, 0);
        send_cmd(ASC, 0);
        chk("plan_asc", id_cur, 32'h0200_0000);
        chk("plan_asc_depth", depth, 1);
        send_cmd(ZERO, 0);
        chk("plan_zero", id_cur, 32'h0);

        // Sticky first error code, then FULL
        do_reset();
        send_cmd(INC, 0);
        chk("plan_noact_code", err_code, 2'd1);
        repeat (4) send_cmd(DESC, 0);
        chk("plan_full_id", id_cur, 32'h0101_0101);
        send_cmd(DESC, 0);
        chk("plan_full_res_err", bus.res_err, 1);
        chk("plan_code_sticky", err_code, 2'd1);

        // INC overflow at 0x01FF0000
        do_reset();
        repeat (2) send_cmd(DESC, 0);
        repeat (254) send_cmd(INC, 0);
        chk("plan_01ff", id_cur, 32'h01FF_0000);
        send_cmd(INC, 0);
        chk("plan_inc_ovf_id", id_cur, 32'h01FF_0000);
        chk("plan_inc_ovf_code", err_code, 2'd2);

        // ASCEND into a saturated outer slot
        do_reset();
        send_cmd(DESC, 0);
        repeat (254) send_cmd(INC, 0);
        send_cmd(DESC, 0);
        chk("plan_ff01", id_cur, 32'hFF01_0000);
        send_cmd(ASC, 0);
        chk("plan_asc_ovf_id", id_cur, 32'hFF01_0000);
        chk("plan_asc_ovf_code", err_code, 2'd2);

        // Backpressure
        send_cmd(ZERO, 10);
        send_cmd(DESC, 10);

        // Reset pulse during SCAN drops the command
        @(negedge clk);
        bus.cmd_valid = 1'b1;
        bus.cmd_op    = DESC;
        bus.res_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.cmd_valid = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        m_id = 0; m_err = 1'b0; m_code = 2'd0;
        chk_reset_outputs();
        seen = 1'b0;
        repeat (10) begin
            @(negedge clk);
            if (bus.res_valid) seen = 1'b1;
        end
        chk("midscan_no_resp", seen, 0);
        bus.res_ready = 1'b0;
        send_cmd(DESC, 0);
        chk("midscan_after", id_cur, 32'h0100_0000);

        // Randomized commands against the model
        for (int n = 0; n < 60; n++) begin
            if ($urandom_range(0, 19) == 0) do_reset();
            op = 2'($urandom_range(0, 3));
            if (op == ZERO && $urandom_range(0, 3) != 0) op = INC;
            send_cmd(op, int'($urandom_range(0, 3)));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end
endmodule

// File: doc/execid_sequencer.md
Name: execid_sequencer

Overview:
- Stateful upstream stage that owns the running execution ID register and applies ZERO / INC / DESCEND / ASCEND commands to it.
- Its output feeds the comparators (GT/GE/EQ) and MAX reducers downstream.
- Uses the same 8-bit slot encoding as the combinational execid primitives:
  - slot i is bits [8i+7:8i];
  - outermost nesting level is the highest slot index;
  - the innermost active level is the lowest-index nonzero slot.
- Slots are scanned serially, one per cycle, to save area. Each command returns one response.

Parameters:
- WIDTH, 32, execution ID width. Must be a multiple of SLOTBITS and ≥16.
- SLOTBITS, 8, slot width. Fixed; the value must not be overridden.
- NSLOTS, WIDTH/SLOTBITS, derived localparam.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous, active-high reset.
- cmd_valid  in  1  command present.
- cmd_ready  out  1  high only in IDLE.
- cmd_op  in  2  0=ZERO, 1=INC, 2=DESCEND, 3=ASCEND.
- res_valid  out  1  response present.
- res_ready  in  1  response consumed.
- res_id  out  WIDTH  ID after the command.
- res_err  out  1  command rejected; ID unchanged.
- id_cur  out  WIDTH  current ID register, continuously visible.
- depth  out  $clog2(NSLOTS+1)  active nesting depth.
- err  out  1  sticky error flag.
- err_code  out  2  code of the first error: 1=NO_ACTIVE, 2=OVERFLOW, 3=FULL.

Behaviour:
- Reset (synchronous, rst high at a clk edge):
  - state=IDLE; id_cur=0, res_id=0, res_valid=0, res_err=0, depth=0, err=0, err_code=0.
  - Reset mid-scan or with a pending response drops the command silently.
- FSM states: IDLE → SCAN → UPDATE → RESP → IDLE.
- IDLE:
  - cmd_ready=1.
  - On cmd_valid at edge T: latch cmd_op, scan index k=0, lo_nz=none, hi_z=none.
- SCAN: cycles T+1..T+NSLOTS, one slot k per cycle, k ascending.
  - If slot k≠0 and lo_nz=none: lo_nz=k.
  - If slot k=0: hi_z=k (last write wins, so this is the highest zero index).
  - After k=NSLOTS-1, go to UPDATE.
- UPDATE: cycle T+NSLOTS+1. The ID register is written only here.
  - ZERO: id=0. Never errors.
  - INC:
    - lo_nz=none → NO_ACTIVE.
    - slot[lo_nz]=0xFF → OVERFLOW.
    - Otherwise slot[lo_nz]+=1.
  - DESCEND:
    - hi_z=none → FULL.
    - Otherwise slot[hi_z]=1.
  - ASCEND:
    - lo_nz=none → NO_ACTIVE.
    - lo_nz=NSLOTS-1, or slot[lo_nz+1]=0xFF → OVERFLOW.
    - Otherwise slot[lo_nz]=0 and slot[lo_nz+1]+=1.
  - On error: id unchanged and res_err=1. If err was 0, set err=1 and err_code=code; later errors do not overwrite it.
  - depth is recomputed from the new id as NSLOTS minus the lowest nonzero index, or 0 if id=0.
- RESP:
  - res_valid=1 from T+NSLOTS+2; res_id=new id.
  - res_id and res_err are held stable until res_valid & res_ready; then go to IDLE.
  - res_ready may be held high in advance, giving a one-cycle RESP.
- Command-to-command minimum spacing is NSLOTS+3 cycles.
- Arithmetic is mod 2^SLOTBITS per slot, but a wrap is always reported as OVERFLOW and never committed.
- cmd_op and the ID value are sampled only at acceptance.
- id_cur changes only in UPDATE, so it is stable while res_valid=1.

Test Plan (WIDTH=32):
- Reset, then DESCEND, DESCEND, INC, INC, INC → res_id sequence 0x01000000, 0x01010000, 0x01020000, 0x01030000, 0x01040000; depth=2; err=0. res_valid rises exactly 6 cycles after each acceptance.
- From 0x01040000, ASCEND → res_id=0x02000000, depth=1. Then ZERO → res_id=0, depth=0.
- From reset, INC → res_err=1, res_id=0, err=1, err_code=1. A later DESCEND, DESCEND, DESCEND, DESCEND (0x01010101), then DESCEND → res_err=1, FULL, but err_code stays 1.
- Slot overflow: drive id to 0x01FF0000 via repeated INC; the next INC → res_err=1, id unchanged, OVERFLOW. ASCEND with top slot=0xFF, e.g. 0xFF010000 → OVERFLOW.
- Backpressure: hold res_ready=0 for 10 cycles → res_valid and res_id stable, cmd_ready=0, id_cur unchanged. Releasing res_ready → IDLE next cycle.
- Pulse rst during SCAN (cycle T+2) → next cycle all outputs at reset values; no response emitted; a new command is accepted normally.
